// File: rtl/gcd_controller_if.sv
// Host-side start/busy/done handshake bundle for gcd_controller.
interface gcd_controller_if #(
    parameter int WIDTH = 10
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] gcd_out;

    modport master (output start, a_in, b_in, input busy, done, err, gcd_out);
    modport slave  (input start, a_in, b_in, output busy, done, err, gcd_out);
endinterface

// File: rtl/gcd_controller.sv
// Sequencing FSM for a subtractive GCD datapath with zero rejection and an iteration limit.
// Optional iteration-count output enabled by defining GCD_ITER_COUNT_EN.
module gcd_controller #(
    parameter int WIDTH    = 10,
    parameter int MAX_ITER = 1023,
    localparam int ITER_W  = $clog2(MAX_ITER + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    gcd_controller_if.slave  host,
    output logic [WIDTH-1:0] dp_a,
    output logic [WIDTH-1:0] dp_b,
    output logic             load_ab,
    output logic [1:0]       minus_sel,
    output logic             finished,
    input  logic [1:0]       who_greater,
    input  logic [WIDTH-1:0] result_in
`ifdef GCD_ITER_COUNT_EN
    ,
    output logic [ITER_W-1:0] iter_count
`endif
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_ZERO   = 4'd1,
        S_LOAD   = 4'd2,
        S_SETTLE = 4'd3,
        S_CMP    = 4'd4,
        S_SUB_A  = 4'd5,
        S_SUB_B  = 4'd6,
        S_FINISH = 4'd7,
        S_DONE   = 4'd8,
        S_ABORT  = 4'd9
    } state_t;

    localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

    state_t            state_r;
    state_t            next_s;
    logic [ITER_W-1:0] iter_r;
    logic [WIDTH-1:0]  dp_a_r;
    logic [WIDTH-1:0]  dp_b_r;
    logic              done_r;
    logic              err_r;
    logic [WIDTH-1:0]  gcd_r;
    logic              busy_s;
    logic              load_ab_s;
    logic [1:0]        minus_sel_s;
    logic              finished_s;
    logic              accept_s;
    logic              zero_op_s;

    assign accept_s  = (state_r == S_IDLE) && host.start;
    assign zero_op_s = (host.a_in == {WIDTH{1'b0}}) || (host.b_in == {WIDTH{1'b0}});

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state decode
    always_comb begin
        next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (host.start) begin
                    if (zero_op_s) begin
                        next_s = S_ZERO;
                    end else begin
                        next_s = S_LOAD;
                    end
                end else begin
                    next_s = S_IDLE;
                end
            end
            S_ZERO:   next_s = S_IDLE;
            S_LOAD:   next_s = S_SETTLE;
            S_SETTLE: next_s = S_CMP;
            S_CMP: begin
                case (who_greater)
                    2'd0:    next_s = S_FINISH;
                    2'd1:    next_s = (iter_r == ITER_MAX) ? S_ABORT : S_SUB_A;
                    2'd2:    next_s = (iter_r == ITER_MAX) ? S_ABORT : S_SUB_B;
                    default: next_s = S_ABORT;
                endcase
            end
            S_SUB_A:  next_s = S_SETTLE;
            S_SUB_B:  next_s = S_SETTLE;
            S_FINISH: next_s = S_DONE;
            S_DONE:   next_s = S_IDLE;
            S_ABORT:  next_s = S_IDLE;
            default:  next_s = S_IDLE;
        endcase
    end

    // Moore datapath controls decoded from the state register
    always_comb begin
        busy_s      = (state_r != S_IDLE);
        load_ab_s   = 1'b0;
        minus_sel_s = 2'd0;
        finished_s  = 1'b0;
        case (state_r)
            S_LOAD:   load_ab_s   = 1'b1;
            S_SUB_A:  minus_sel_s = 2'd1;
            S_SUB_B:  minus_sel_s = 2'd2;
            S_FINISH: finished_s  = 1'b1;
            default: begin
                load_ab_s   = 1'b0;
                minus_sel_s = 2'd0;
                finished_s  = 1'b0;
            end
        endcase
    end

    // Operand latch and subtraction counter; operands only change on an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_a_r <= {WIDTH{1'b0}};
            dp_b_r <= {WIDTH{1'b0}};
            iter_r <= {ITER_W{1'b0}};
        end else if (accept_s) begin
            dp_a_r <= host.a_in;
            dp_b_r <= host.b_in;
            iter_r <= {ITER_W{1'b0}};
        end else if (next_s == S_SUB_A || next_s == S_SUB_B) begin
            iter_r <= iter_r + ITER_W'(1);
        end
    end

    // Registered completion status; gcd_out/err hold until the next completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            gcd_r  <= {WIDTH{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_ZERO, S_ABORT: begin
                    done_r <= 1'b1;
                    err_r  <= 1'b1;
                    gcd_r  <= {WIDTH{1'b0}};
                end
                S_DONE: begin
                    done_r <= 1'b1;
                    err_r  <= 1'b0;
                    gcd_r  <= result_in;
                end
                default: begin
                    err_r <= err_r;
                    gcd_r <= gcd_r;
                end
            endcase
        end
    end

`ifdef GCD_ITER_COUNT_EN
    logic [ITER_W-1:0] iter_count_r;

    // Subtraction count published alongside done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter_count_r <= {ITER_W{1'b0}};
        end else begin
            case (state_r)
                S_ZERO:          iter_count_r <= {ITER_W{1'b0}};
                S_DONE, S_ABORT: iter_count_r <= iter_r;
                default:         iter_count_r <= iter_count_r;
            endcase
        end
    end

    assign iter_count = iter_count_r;
`endif

    assign host.busy    = busy_s;
    assign host.done    = done_r;
    assign host.err     = err_r;
    assign host.gcd_out = gcd_r;
    assign dp_a         = dp_a_r;
    assign dp_b         = dp_b_r;
    assign load_ab      = load_ab_s;
    assign minus_sel    = minus_sel_s;
    assign finished     = finished_s;

endmodule

// File: tb/tb_gcd_controller.sv
// Self-checking bench for gcd_controller: behavioural datapath plus Euclid-based reference model.
module tb_gcd_controller;
    localparam int W = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   mseq;
    bit   ld_seen;

    always #5 clk = ~clk;

    gcd_controller_if #(.WIDTH(W)) bus0 ();
    gcd_controller_if #(.WIDTH(W)) bus1 ();

    logic [W-1:0] dpa [2];
    logic [W-1:0] dpb [2];
    logic [W-1:0] res [2];
    logic [W-1:0] rega [2];
    logic [W-1:0] regb [2];
    logic         ld  [2];
    logic         fin [2];
    logic [1:0]   msel [2];
    logic [1:0]   wg   [2];
`ifdef GCD_ITER_COUNT_EN
    logic [9:0]   ic0;
    logic [1:0]   ic1;
`endif

    gcd_controller #(.WIDTH(W), .MAX_ITER(1023)) dut0 (
        .clk(clk), .rst_n(rst_n), .host(bus0),
        .dp_a(dpa[0]), .dp_b(dpb[0]), .load_ab(ld[0]), .minus_sel(msel[0]),
        .finished(fin[0]), .who_greater(wg[0]), .result_in(res[0])
`ifdef GCD_ITER_COUNT_EN
        , .iter_count(ic0)
`endif
    );

    gcd_controller #(.WIDTH(W), .MAX_ITER(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .host(bus1),
        .dp_a(dpa[1]), .dp_b(dpb[1]), .load_ab(ld[1]), .minus_sel(msel[1]),
        .finished(fin[1]), .who_greater(wg[1]), .result_in(res[1])
`ifdef GCD_ITER_COUNT_EN
        , .iter_count(ic1)
`endif
    );

    // Behavioural subtractive datapath (no reset, reloaded by load_ab)
    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (ld[k]) begin
                rega[k] <= dpa[k];
                regb[k] <= dpb[k];
            end else if (msel[k] == 2'd1) begin
                rega[k] <= rega[k] - regb[k];
            end else if (msel[k] == 2'd2) begin
                regb[k] <= regb[k] - rega[k];
            end
            if (fin[k]) res[k] <= rega[k];
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            wg[k] = (rega[k] == regb[k]) ? 2'd0 : ((rega[k] > regb[k]) ? 2'd1 : 2'd2);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Division-based Euclid: subtraction count is the sum of quotients minus the final one
    function automatic void ref_gcd(input int a, input int b, output int g, output int n);
        int x, y, t, s;
        x = (a > b) ? a : b;
        y = (a > b) ? b : a;
        s = 0;
        while (y != 0) begin
            s += x / y;
            t = x % y;
            x = y;
            y = t;
        end
        g = x;
        n = s - 1;
    endfunction

    // Issue one operation on dut0 and check its completion; returns in the done cycle
    task automatic run0(input int a, input int b);
        int g, n, lat, e, cyc;
        if (a == 0 || b == 0) begin
            g = 0; n = 0; e = 1; lat = 2;
        end else begin
            ref_gcd(a, b, g, n);
            e = 0;
            lat = 6 + 3 * n;
        end
        mseq = 0;
        ld_seen = 1'b0;
        bus0.a_in  = W'(a);
        bus0.b_in  = W'(b);
        bus0.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus0.start = 1'b0;
        cyc = 1;
        while (bus0.done !== 1'b1 && cyc < 4000) begin
            if (msel[0] != 2'd0) mseq = mseq * 4 + int'(msel[0]);
            if (ld[0]) ld_seen = 1'b1;
            @(negedge clk);
            cyc++;
        end
        chk("latency", cyc, lat);
        chk("gcd_out", bus0.gcd_out, g);
        chk("err", bus0.err, e);
        chk("busy_at_done", bus0.busy, 0);
        chk("dp_a_stable", dpa[0], a);
        chk("dp_b_stable", dpb[0], b);
`ifdef GCD_ITER_COUNT_EN
        chk("iter_count", ic0, n);
`endif
    endtask

    initial begin
        int cyc;
        bus0.start = 1'b0; bus0.a_in = '0; bus0.b_in = '0;
        bus1.start = 1'b0; bus1.a_in = '0; bus1.b_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus0.busy, 0);
        chk("rst_done", bus0.done, 0);
        chk("rst_err", bus0.err, 0);
        chk("rst_gcd", bus0.gcd_out, 0);
        chk("rst_load", ld[0], 0);
        chk("rst_msel", msel[0], 0);
        chk("rst_dpa", dpa[0], 0);
        rst_n = 1'b1;
        @(negedge clk);

        run0(12, 18);
        chk("seq_12_18", mseq, 9);
        @(negedge clk);
        chk("done_one_cycle", bus0.done, 0);
        run0(48, 18);
        @(negedge clk);
        run0(7, 7);
        chk("seq_7_7", mseq, 0);
        run0(5, 10);
        @(negedge clk);
        run0(0, 5);
        chk("zero_no_load", ld_seen, 0);
        @(negedge clk);
        run0(5, 0);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            run0(int'($urandom_range(1, 1023)), int'($urandom_range(1, 1023)));
            @(negedge clk);
        end

        // Iteration-limit abort on the MAX_ITER=3 instance, with a stray start mid-run
        bus1.a_in = W'(1023); bus1.b_in = W'(1); bus1.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus1.start = 1'b0;
        cyc = 1;
        while (bus1.done !== 1'b1 && cyc < 100) begin
            if (cyc == 5) begin
                bus1.start = 1'b1; bus1.a_in = W'(7); bus1.b_in = W'(7);
            end else begin
                bus1.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus1.start = 1'b0;
        chk("abort_latency", cyc, 14);
        chk("abort_err", bus1.err, 1);
        chk("abort_gcd", bus1.gcd_out, 0);
        chk("abort_dpa_held", dpa[1], 1023);
`ifdef GCD_ITER_COUNT_EN
        chk("abort_iter", ic1, 3);
`endif
        @(negedge clk);
        chk("stray_start_dropped", bus1.busy, 0);

        // Reset in the middle of a long run
        bus0.a_in = W'(1000); bus0.b_in = W'(3); bus0.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus0.start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", bus0.busy, 0);
        chk("mid_rst_done", bus0.done, 0);
        chk("mid_rst_gcd", bus0.gcd_out, 0);
        chk("mid_rst_err", bus1.err, 0);
        chk("mid_rst_dpa", dpa[0], 0);
        chk("mid_rst_msel", msel[0], 0);
        chk("mid_rst_load", ld[0], 0);
        chk("mid_rst_fin", fin[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", bus0.busy, 0);
        run0(9, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
